cond_unit: RTL and testbench

Per-thread conditional-execution unit for the processor datapath. It holds a NZCV flag register per hardware thread and evaluates the 4-bit condition field of each issued instruction against that thread's flags. Flag writes are gated by the condition result. A predication-block counter lets one "set block" instruction apply a single condition to the next N instructions of the same thread. It sits between decode and the register-file/memory write enables, replacing the purely combinational condition check.

---
 rtl/cond_unit.sv | 156 +++++++++++++++
 tb/tb_cond_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Per-thread conditional-execution unit: NZCV flag banks, condition evaluation
// and a per-thread predication-block counter that overrides the condition field.
module cond_unit #(
    parameter  int THREADS = 2,
    parameter  int IT_MAX  = 4,
    localparam int TW      = (THREADS > 1) ? $clog2(THREADS) : 1,
    localparam int CW      = $clog2(IT_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_i,
    input  logic [TW-1:0] tid_i,
    input  logic [3:0]    cond_i,
    input  logic [3:0]    alu_flags_i,
    input  logic [1:0]    flag_w_i,
    input  logic          set_it_i,
    input  logic [3:0]    it_cond_i,
    input  logic [CW-1:0] it_len_i,
    input  logic          flush_i,
    output logic          cond_ex_o,
    output logic [3:0]    flags_o,
    output logic          it_active_o,
    output logic [CW-1:0] it_remaining_o
);

    localparam logic [CW-1:0] IT_MAX_C  = CW'(IT_MAX);
    localparam logic [TW:0]   THREADS_C = (TW + 1)'(THREADS);
    localparam logic [3:0]    COND_AL   = 4'b1110;

    // Condition-code evaluation against {N,Z,C,V}; every code yields a defined value.
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, ge;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        ge = (n == v);
        case (c)
            4'b0000: eval_cond = z;
            4'b0001: eval_cond = ~z;
            4'b0010: eval_cond = cf;
            4'b0011: eval_cond = ~cf;
            4'b0100: eval_cond = n;
            4'b0101: eval_cond = ~n;
            4'b0110: eval_cond = v;
            4'b0111: eval_cond = ~v;
            4'b1000: eval_cond = cf & ~z;
            4'b1001: eval_cond = ~(cf & ~z);
            4'b1010: eval_cond = ge;
            4'b1011: eval_cond = ~ge;
            4'b1100: eval_cond = ~z & ge;
            4'b1101: eval_cond = ~(~z & ge);
            4'b1110: eval_cond = 1'b1;
            4'b1111: eval_cond = 1'b0;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    logic [3:0]    flags_q [THREADS];
    logic [3:0]    flags_d [THREADS];
    logic [CW-1:0] cnt_q   [THREADS];
    logic [CW-1:0] cnt_d   [THREADS];
    logic [3:0]    itc_q   [THREADS];
    logic [3:0]    itc_d   [THREADS];

    logic          tid_ok_s;
    logic          inst_ok_s;
    logic [TW-1:0] sel_s;
    logic [CW-1:0] cur_cnt_s;
    logic [3:0]    cur_flags_s;
    logic [3:0]    eff_cond_s;
    logic          cond_ex_s;

    // Select the addressed bank and decide whether this instruction executes.
    always_comb begin
        tid_ok_s    = ({1'b0, tid_i} < THREADS_C);
        inst_ok_s   = valid_i & tid_ok_s;
        sel_s       = tid_ok_s ? tid_i : '0;
        cur_cnt_s   = cnt_q[sel_s];
        cur_flags_s = flags_q[sel_s];
        eff_cond_s  = (cur_cnt_s != '0) ? itc_q[sel_s] : cond_i;
        if (!inst_ok_s || flush_i) begin
            cond_ex_s = 1'b0;
        end else if (set_it_i) begin
            cond_ex_s = 1'b1;
        end else begin
            cond_ex_s = eval_cond(eff_cond_s, cur_flags_s);
        end
    end

    // Next-state for flag banks and predication counters of the addressed thread.
    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        itc_d   = itc_q;
        if (cond_ex_s && !set_it_i) begin
            flags_d[sel_s][3:2] = flag_w_i[1] ? alu_flags_i[3:2] : cur_flags_s[3:2];
            flags_d[sel_s][1:0] = flag_w_i[0] ? alu_flags_i[1:0] : cur_flags_s[1:0];
        end else begin
            flags_d[sel_s] = cur_flags_s;
        end
        // Flush beats a setup, which beats a slot being consumed.
        if (flush_i) begin
            for (int i = 0; i < THREADS; i++) begin
                cnt_d[i] = '0;
            end
        end else if (inst_ok_s && set_it_i) begin
            if (it_len_i != '0) begin
                cnt_d[sel_s] = (it_len_i > IT_MAX_C) ? IT_MAX_C : it_len_i;
                itc_d[sel_s] = it_cond_i;
            end else begin
                cnt_d[sel_s] = cur_cnt_s;
            end
        end else if (inst_ok_s && (cur_cnt_s != '0)) begin
            cnt_d[sel_s] = cur_cnt_s - CW'(1);
        end else begin
            cnt_d[sel_s] = cur_cnt_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < THREADS; i++) begin
                flags_q[i] <= 4'b0000;
                cnt_q[i]   <= '0;
                itc_q[i]   <= COND_AL;
            end
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            itc_q   <= itc_d;
        end
    end

    // Outputs read pre-update state and are held quiet during reset.
    always_comb begin
        if (reset) begin
            cond_ex_o      = 1'b0;
            flags_o        = 4'b0000;
            it_active_o    = 1'b0;
            it_remaining_o = '0;
        end else if (tid_ok_s) begin
            cond_ex_o      = cond_ex_s;
            flags_o        = cur_flags_s;
            it_active_o    = (cur_cnt_s != '0);
            it_remaining_o = cur_cnt_s;
        end else begin
            cond_ex_o      = 1'b0;
            flags_o        = 4'b0000;
            it_active_o    = 1'b0;
            it_remaining_o = '0;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cond_unit;

    localparam int THREADS = 2;
    localparam int IT_MAX  = 4;
    localparam int TW      = 1;
    localparam int CW      = 3;

    typedef struct packed {
        logic          ce;
        logic [3:0]    fl;
        logic          act;
        logic [CW-1:0] rem;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, valid_i, set_it_i, flush_i;
    logic [TW-1:0] tid_i;
    logic [3:0]    cond_i, alu_flags_i, it_cond_i;
    logic [1:0]    flag_w_i;
    logic [CW-1:0] it_len_i;
    logic          cond_ex_o, it_active_o;
    logic [3:0]    flags_o;
    logic [CW-1:0] it_remaining_o;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state, kept as plain integers.
    int m_flags [THREADS];
    int m_cnt   [THREADS];
    int m_itc   [THREADS];

    cond_unit #(.THREADS(THREADS), .IT_MAX(IT_MAX)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .tid_i(tid_i),
        .cond_i(cond_i), .alu_flags_i(alu_flags_i), .flag_w_i(flag_w_i),
        .set_it_i(set_it_i), .it_cond_i(it_cond_i), .it_len_i(it_len_i),
        .flush_i(flush_i), .cond_ex_o(cond_ex_o), .flags_o(flags_o),
        .it_active_o(it_active_o), .it_remaining_o(it_remaining_o)
    );

    always #5 clk = ~clk;

    // Conditions come in pairs: even code tests a predicate, odd code its inverse.
    function automatic bit holds(input int c, input int f);
        bit n, z, cy, v, r;
        n  = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c >> 1)
            0: r = z;
            1: r = cy;
            2: r = n;
            3: r = v;
            4: r = cy && !z;
            5: r = (n == v);
            6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return (c % 2 == 1) ? !r : r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < THREADS; i++) begin
            m_flags[i] = 0; m_cnt[i] = 0; m_itc[i] = 14;
        end
    endtask

    // Drive one cycle of inputs, predict the outputs, advance the model.
    // fce/frem >= 0 pin the expected cond_ex / remaining to a hand-derived value.
    task automatic issue(input bit rst, input bit v, input int t, input int c,
                         input int af, input int fw, input bit si, input int ic,
                         input int il, input bit fl, input int fce, input int frem);
        exp_t e;
        bit ce;
        @(posedge clk); #1;
        reset = rst; valid_i = v; tid_i = t[TW-1:0]; cond_i = c[3:0];
        alu_flags_i = af[3:0]; flag_w_i = fw[1:0]; set_it_i = si;
        it_cond_i = ic[3:0]; it_len_i = il[CW-1:0]; flush_i = fl;
        if (rst) begin
            e = '0;
            model_reset();
        end else begin
            if (!v || fl)   ce = 1'b0;
            else if (si)    ce = 1'b1;
            else            ce = holds((m_cnt[t] > 0) ? m_itc[t] : c, m_flags[t]);
            e.ce  = ce;
            e.fl  = m_flags[t][3:0];
            e.act = (m_cnt[t] > 0);
            e.rem = m_cnt[t][CW-1:0];
            if (v && ce && !si && !fl) begin
                if (fw[1]) m_flags[t] = (m_flags[t] & 3) | (af & 12);
                if (fw[0]) m_flags[t] = (m_flags[t] & 12) | (af & 3);
            end
            if (fl) begin
                for (int i = 0; i < THREADS; i++) m_cnt[i] = 0;
            end else if (v && si) begin
                if (il > 0) begin
                    m_cnt[t] = (il > IT_MAX) ? IT_MAX : il;
                    m_itc[t] = ic;
                end
            end else if (v && m_cnt[t] > 0) begin
                m_cnt[t] = m_cnt[t] - 1;
            end
        end
        if (fce >= 0) e.ce = fce[0];
        if (frem >= 0) begin
            e.rem = frem[CW-1:0];
            e.act = (frem > 0);
        end
        q.push_back(e);
    endtask

    task automatic ins(input int t, input int c, input int af, input int fw,
                       input int fce, input int frem);
        issue(1'b0, 1'b1, t, c, af, fw, 1'b0, 0, 0, 1'b0, fce, frem);
    endtask

    task automatic setb(input int t, input int ic, input int il, input int frem);
        issue(1'b0, 1'b1, t, 0, 0, 0, 1'b1, ic, il, 1'b0, 1, frem);
    endtask

    // Monitor: compare DUT outputs with the oldest expectation away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (cond_ex_o !== e.ce || flags_o !== e.fl ||
                    it_active_o !== e.act || it_remaining_o !== e.rem) begin
                    bad++;
                    $display("FAIL outputs #%0d: got ce=%b flags=%b act=%b rem=%0d, want ce=%b flags=%b act=%b rem=%0d",
                             total, cond_ex_o, flags_o, it_active_o, it_remaining_o,
                             e.ce, e.fl, e.act, e.rem);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; valid_i = 1'b0; tid_i = '0; cond_i = '0; alu_flags_i = '0;
        flag_w_i = '0; set_it_i = 1'b0; it_cond_i = '0; it_len_i = '0; flush_i = 1'b0;
        model_reset();

        // Reset state, with a valid AL instruction presented during reset.
        issue(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        issue(1'b1, 1'b1, 0, 14, 15, 3, 1'b0, 0, 0, 1'b0, 0, 0);

        // Basic evaluation and flag write.
        ins(0, 0, 0, 3, 0, 0);          // EQ with Z=0
        ins(0, 14, 4, 3, 1, 0);         // AL writes 0100
        ins(0, 0, 0, 0, 1, 0);          // EQ now passes
        ins(0, 1, 8, 3, 0, 0);          // NE fails, write suppressed
        ins(0, 14, 3, 1, 1, 0);         // C,V only -> 0111
        ins(0, 14, 9, 3, 1, 0);         // flags -> 1001
        // Thread isolation with GE.
        ins(1, 10, 0, 0, 1, 0);
        ins(0, 10, 0, 0, 1, 0);

        // Block on tid 0 with EQ, Z=0.
        setb(0, 0, 3, 0);
        ins(0, 14, 0, 0, 0, 3);
        ins(0, 14, 0, 0, 0, 2);
        ins(0, 14, 0, 0, 0, 1);
        ins(0, 14, 0, 0, 1, 0);

        // Block edge cases: clamp, re-set mid-block, zero length, flush.
        setb(0, 14, 7, 0);
        ins(0, 15, 0, 0, 1, 4);
        setb(0, 14, 2, 3);
        ins(0, 15, 0, 0, 1, 2);
        setb(0, 15, 0, 1);
        ins(0, 14, 0, 0, 1, 1);
        setb(0, 14, 3, 0);
        issue(1'b0, 1'b1, 0, 14, 0, 3, 1'b0, 0, 0, 1'b1, 0, 3);
        ins(0, 15, 0, 0, 0, 0);

        // Reset mid-block; the first instruction afterwards uses cond_i.
        setb(1, 14, 4, 0);
        ins(1, 15, 0, 0, 1, 4);
        issue(1'b1, 1'b1, 1, 14, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        ins(1, 15, 0, 0, 0, 0);

        // Sweep every condition against every flag value on tid 1.
        for (int f = 0; f < 16; f++) begin
            ins(1, 14, f, 3, 1, -1);
            for (int c = 0; c < 16; c++) ins(1, c, 0, 0, -1, -1);
            ins(1, 15, 0, 3, 0, -1);
        end

        // Random multi-thread stream.
        for (int n = 0; n < 2000; n++) begin
            issue(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) != 0),
                  $urandom_range(0, THREADS - 1), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
                  $urandom_range(0, 7), ($urandom_range(0, 49) == 0), -1, -1);
        end

        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0; set_it_i = 1'b0; reset = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
